// File: rtl/fpu_pkg.sv
// Shared FPU definitions.
// - div_state_e : sequencer states of the iterative divider
// - FP32 field positions, exponent bias, quotient width
// - FP32 constant patterns (infinity, zero)
package fpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_NORM = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_W   = 23;

  localparam int EXP_BIAS = 127;
  // 1 integer bit + 24 fraction bits of quotient.
  localparam int QBITS    = 25;

  localparam logic [31:0] FP32_INF  = 32'h7F80_0000;
  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fpu_div_step.sv
// One restoring-division step, purely combinational.
// Ports:
//   rem_in  [24:0] in  partial remainder, always < 2*mb
//   mb      [23:0] in  divisor mantissa with hidden bit (bit 23 set)
//   rem_out [24:0] out next partial remainder, already shifted left by one
//   qbit           out quotient bit produced by this step
module fpu_div_step (
  input  logic [24:0] rem_in,
  input  logic [23:0] mb,
  output logic [24:0] rem_out,
  output logic        qbit
);

  logic [23:0] diff;

  always_comb begin
    qbit = (rem_in >= {1'b0, mb});
    // When the subtraction is taken the difference is < mb < 2^24, so the
    // low 24 bits of the subtraction are the whole result.
    diff = rem_in[23:0] - mb;
    if (qbit) begin
      rem_out = {diff, 1'b0};
    end else begin
      // Not taken means rem_in < mb < 2^24, so the shift cannot overflow.
      rem_out = {rem_in[23:0], 1'b0};
    end
  end

endmodule

// File: rtl/fpu_div_seq.sv
// Sequenced IEEE-754 single-precision divider, result = A / B.
// One restoring quotient bit per clock, truncating, one divide in flight.
// Handshake: a request is taken on a rising edge where in_valid & in_ready;
// a result is taken on a rising edge where out_valid & out_ready. out_valid,
// result and dz are held stable until taken; in_ready is low from accept
// until the edge after the result is taken.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  request handshake (in_ready = idle)
//   A, B [31:0]          dividend, divisor (sampled only on the accept edge)
//   out_valid/out_ready  response handshake
//   result [31:0]        quotient
//   dz                   divide-by-zero flag, qualified by out_valid
//   busy                 any state other than idle
module fpu_div_seq #(
  parameter int EXP_BIAS = 127,
  // Only 25 is supported: the datapath widths are fixed around it.
  parameter int QBITS    = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        dz,
  output logic        busy
);
  import fpu_pkg::*;

  localparam logic [7:0] BIAS8    = 8'(EXP_BIAS);
  localparam logic [4:0] LAST_CNT = 5'(QBITS - 1);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt;
  logic [24:0] rem;
  logic [23:0] mb;
  logic [24:0] q;
  logic        sign;
  logic [7:0]  exp;

  logic [7:0]  a_exp, b_exp, exp_acc;
  logic        sign_in, b_zero, a_zero, special, last_iter;
  logic [24:0] rem_next;
  logic        qbit;

  assign a_exp     = A[EXP_MSB:EXP_LSB];
  assign b_exp     = B[EXP_MSB:EXP_LSB];
  assign sign_in   = A[SIGN_BIT] ^ B[SIGN_BIT];
  // 8-bit wrap on purpose: overflow/underflow is not flagged.
  assign exp_acc   = a_exp - b_exp + BIAS8;
  // Zero exponent covers zero and denormals (flushed to zero).
  assign b_zero    = (b_exp == 8'd0);
  assign a_zero    = (a_exp == 8'd0);
  assign special   = b_zero | a_zero;
  assign last_iter = (cnt == LAST_CNT);

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);

  fpu_div_step u_step (
    .rem_in  (rem),
    .mb      (mb),
    .rem_out (rem_next),
    .qbit    (qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = special ? S_DONE : S_DIV;
      S_DIV:   if (last_iter) state_d = S_NORM;
      S_NORM:  state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 5'd0;
      rem    <= 25'd0;
      mb     <= 24'd0;
      q      <= 25'd0;
      sign   <= 1'b0;
      exp    <= 8'd0;
      result <= FP32_ZERO;
      dz     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            sign <= sign_in;
            exp  <= exp_acc;
            rem  <= {2'b01, A[MANT_W-1:0]};
            mb   <= {1'b1, B[MANT_W-1:0]};
            q    <= 25'd0;
            cnt  <= 5'd0;
            // Zero divisor wins over zero dividend.
            if (b_zero) begin
              result <= FP32_INF | {sign_in, 31'd0};
              dz     <= 1'b1;
            end else if (a_zero) begin
              result <= {sign_in, 31'd0};
              dz     <= 1'b0;
            end
          end
        end
        S_DIV: begin
          q   <= {q[23:0], qbit};
          rem <= rem_next;
          cnt <= cnt + 5'd1;
        end
        S_NORM: begin
          // q is in [2^23, 2^25): at most one position of normalisation.
          if (q[24]) begin
            result <= {sign, exp, q[23:1]};
          end else begin
            result <= {sign, exp - 8'd1, q[22:0]};
          end
          dz <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_div_seq.sv
module tb_fpu_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        dz;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // {dz, result} expectations and their latencies, in issue order
  logic [32:0] exp_q[$];
  int          lat_q[$];

  fpu_div_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .dz        (dz),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // Floating-point quotient from the rules: exact integer quotient of the
  // significands, one normalisation step, truncation, wrapped exponent.
  function automatic logic [32:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    logic [7:0]  ex, ey, e8;
    longint      mx, my, qq, mant;
    int          e;
    s  = x[31] ^ y[31];
    ex = x[30:23];
    ey = y[30:23];
    if (ey == 8'd0) return {1'b1, s, 8'hFF, 23'd0};
    if (ex == 8'd0) return {1'b0, s, 31'd0};
    mx = longint'(x[22:0]) + (longint'(1) << 23);
    my = longint'(y[22:0]) + (longint'(1) << 23);
    qq = (mx << 24) / my;
    e  = int'(ex) - int'(ey) + 127;
    if (qq >= (longint'(1) << 24)) begin
      mant = (qq >> 1) % (longint'(1) << 23);
    end else begin
      mant = qq % (longint'(1) << 23);
      e    = e - 1;
    end
    e8 = e[7:0];
    return {1'b0, s, e8, mant[22:0]};
  endfunction

  function automatic int ref_lat(input logic [31:0] x, input logic [31:0] y);
    // Edge index at which out_valid rises, the accepting edge being the 1st.
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return 1;
    return 27;
  endfunction

  // ---------------- driver tasks ----------------
  // Presents a request, waits for acceptance, then counts edges until
  // out_valid (accepting edge = 1). Leaves the result un-retired.
  task automatic do_div(input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output logic z, output int lat);
    int guard;
    @(negedge clk);
    a = x;
    b = y;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    // Operands are free to change once accepted.
    a = $urandom;
    b = $urandom;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    r = result;
    z = dz;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 00000000", result); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", dz); end
  endtask

  task automatic test_directed();
    logic [31:0] va[5], vb[5], vr[5];
    logic        vz[5];
    int          vl[5];
    logic [31:0] r;
    logic        z;
    int          lat;
    va = '{32'h40C00000, 32'h3F800000, 32'hBFC00000, 32'h3F800000, 32'h80000000};
    vb = '{32'h40000000, 32'h40400000, 32'h3F000000, 32'h00000000, 32'h40000000};
    vr = '{32'h40400000, 32'h3EAAAAAA, 32'hC0400000, 32'h7F800000, 32'h80000000};
    vz = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vl = '{27, 27, 27, 1, 1};
    for (int i = 0; i < 5; i++) begin
      do_div(va[i], vb[i], r, z, lat);
      checks++; if (r !== vr[i]) begin errors++; $display("FAIL directed_result[%0d] got %h want %h", i, r, vr[i]); end
      checks++; if (z !== vz[i]) begin errors++; $display("FAIL directed_dz[%0d] got %b want %b", i, z, vz[i]); end
      checks++; if (lat !== vl[i]) begin errors++; $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, vl[i]); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL directed_busy_done[%0d] got %b want 1", i, busy); end
      retire();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++; $display("FAIL directed_retire[%0d] got in_ready=%b out_valid=%b want 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    logic        z;
    int          lat;
    do_div(32'h40C00000, 32'h40000000, r, z, lat);
    checks++; if (r !== 32'h40400000) begin errors++; $display("FAIL bp_result got %h want 40400000", r); end
    // A competing request is presented while the result is held.
    in_valid = 1'b1;
    a = 32'h3F800000;
    b = 32'h40400000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = $urandom;
      b = $urandom | 32'h00800000;
      checks++; if (out_valid !== 1'b1 || result !== 32'h40400000 || dz !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got ov=%b res=%h dz=%b ir=%b want 1 40400000 0 0", i, out_valid, result, dz, in_ready);
      end
    end
    in_valid = 1'b0;
    retire();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release got ir=%b ov=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic        z;
    int          lat;
    @(negedge clk);
    a = 32'h40C00000;
    b = 32'h40000000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset got ov=%b busy=%b ir=%b want 0 0 1", out_valid, busy, in_ready);
    end
    // The dropped divide must not surface later.
    repeat (30) begin
      @(negedge clk);
      if (out_valid !== 1'b0) break;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_output got ov=%b want 0", out_valid); end
    do_div(32'h40C00000, 32'h40000000, r, z, lat);
    checks++; if (r !== 32'h40400000 || z !== 1'b0 || lat !== 27) begin
      errors++; $display("FAIL mid_fresh got res=%h dz=%b lat=%0d want 40400000 0 27", r, z, lat);
    end
    retire();
  endtask

  task automatic test_back_to_back();
    logic [31:0] x, y, r;
    logic        z;
    int          lat, want_lat;
    logic [32:0] want;
    for (int i = 0; i < 60; i++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y[30:23] = 8'd0;
        1: x[30:23] = 8'd0;
        2: begin x[30:23] = 8'd0; y[30:23] = 8'd0; end
        default: ;
      endcase
      exp_q.push_back(ref_div(x, y));
      lat_q.push_back(ref_lat(x, y));
      do_div(x, y, r, z, lat);
      want = exp_q.pop_front();
      want_lat = lat_q.pop_front();
      checks++; if ({z, r} !== want) begin
        errors++; $display("FAIL rand[%0d] a=%h b=%h got dz=%b res=%h want dz=%b res=%h", i, x, y, z, r, want[32], want[31:0]);
      end
      checks++; if (lat !== want_lat) begin
        errors++; $display("FAIL rand_latency[%0d] got %0d want %0d", i, lat, want_lat);
      end
      retire();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 32'h0;
    b         = 32'h0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
